// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state codes, read-owner codes,
// counter width and small helpers used by both the FSM and the top level.
package dmem_arbiter_pkg;

    // Arbiter mode
    localparam logic ST_CPU_PRI   = 1'b0;
    localparam logic ST_DMA_BURST = 1'b1;

    // Which requester owns the read data returning this cycle
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    // Wait and beat counters only ever hold 0..15
    localparam int unsigned CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    // Increment that sticks at the limit instead of wrapping
    function automatic cnt_t sat_inc(input cnt_t val, input cnt_t limit);
        cnt_t res;
        if (val >= limit) begin
            res = limit;
        end else begin
            res = val + cnt_t'(1);
        end
        return res;
    endfunction

    // Owner of the read issued this cycle; writes and idle cycles own nothing
    function automatic logic [1:0] rd_owner_of(input logic cpu_gnt, input logic cpu_we,
                                               input logic dma_gnt, input logic dma_we);
        logic [1:0] own;
        own = OWN_NONE;
        if (cpu_gnt && !cpu_we) begin
            own = OWN_CPU;
        end else if (dma_gnt && !dma_we) begin
            own = OWN_DMA;
        end
        return own;
    endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// Grant decision for the shared data-memory port. CPU has fixed priority in normal
// mode; a starvation counter forces a DMA grant, and a locked DMA burst keeps the
// port for up to MAX_BURST beats.
module dmem_arb_fsm
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req_i,
    input  logic dma_req_i,
    input  logic dma_lock_i,
    output logic cpu_gnt_o,
    output logic dma_gnt_o
);

    localparam cnt_t MaxWait  = cnt_t'(MAX_WAIT);
    localparam cnt_t MaxBurst = cnt_t'(MAX_BURST);
    // A one-beat burst is just a normal grant, so the lock never opens a burst then
    localparam bit   BurstEn  = (MAX_BURST > 1);

    logic state_q, state_d;
    cnt_t wait_q,  wait_d;
    cnt_t beat_q,  beat_d;

    logic cpu_gnt, dma_gnt;
    cnt_t beat_inc;

    assign beat_inc = beat_q + cnt_t'(1);

    // State and counter registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_CPU_PRI;
            wait_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
        end
    end

    // Next state, starvation counter and burst beat counter
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;

        // Counts only consecutive denied DMA cycles
        if (!dma_req_i || dma_gnt) begin
            wait_d = '0;
        end else begin
            wait_d = sat_inc(wait_q, MaxWait);
        end

        case (state_q)
            ST_CPU_PRI: begin
                if (BurstEn && dma_gnt && dma_lock_i) begin
                    state_d = ST_DMA_BURST;
                    beat_d  = cnt_t'(1);
                end else begin
                    beat_d  = '0;
                end
            end
            ST_DMA_BURST: begin
                if (!dma_req_i) begin
                    // Requester walked away: give the port back with no grant
                    state_d = ST_CPU_PRI;
                    beat_d  = '0;
                    wait_d  = '0;
                end else if (!dma_lock_i || beat_inc == MaxBurst) begin
                    // Last beat: either unlocked or the burst length cap is hit
                    state_d = ST_CPU_PRI;
                    beat_d  = '0;
                    wait_d  = '0;
                end else begin
                    beat_d  = beat_inc;
                end
            end
            default: begin
                state_d = ST_CPU_PRI;
                beat_d  = '0;
                wait_d  = '0;
            end
        endcase
    end

    // Grant decision from the current-cycle requests; nothing granted under reset
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_CPU_PRI: begin
                    if (dma_req_i && (wait_q == MaxWait)) begin
                        dma_gnt = 1'b1;
                    end else if (cpu_req_i) begin
                        cpu_gnt = 1'b1;
                    end else if (dma_req_i) begin
                        dma_gnt = 1'b1;
                    end
                end
                ST_DMA_BURST: begin
                    dma_gnt = dma_req_i;
                end
                default: begin
                    cpu_gnt = 1'b0;
                    dma_gnt = 1'b0;
                end
            endcase
        end
    end

    assign cpu_gnt_o = cpu_gnt;
    assign dma_gnt_o = dma_gnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the 128-word data SRAM port between the core load/store path and a DMA /
// loader. Drives the active-low SRAM controls from the winner in the grant cycle and
// routes the registered read data back to whichever requester issued the read.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned AW        = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    // Core load/store side
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    // DMA / loader side
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [31:0]   dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [31:0]   dma_rdata,
    // SRAM macro side
    output logic          CEN,
    output logic          WEN,
    output logic          OEN,
    output logic [AW-1:0] A,
    output logic [31:0]   Data2Mem,
    input  logic [31:0]   ReadDataMem
);

    logic       gnt_any;
    logic       sel_we;
    logic [1:0] rd_owner_q, rd_owner_d;

    dmem_arb_fsm #(
        .MAX_WAIT  (MAX_WAIT),
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req_i  (cpu_req),
        .dma_req_i  (dma_req),
        .dma_lock_i (dma_lock),
        .cpu_gnt_o  (cpu_gnt),
        .dma_gnt_o  (dma_gnt)
    );

    assign gnt_any   = cpu_gnt | dma_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Memory drive: mux the winner's command onto the SRAM pins, park at zero when idle
    always_comb begin
        sel_we   = 1'b0;
        A        = '0;
        Data2Mem = '0;
        if (dma_gnt) begin
            sel_we   = dma_we;
            A        = dma_addr;
            Data2Mem = dma_wdata;
        end else if (cpu_gnt) begin
            sel_we   = cpu_we;
            A        = cpu_addr;
            Data2Mem = cpu_wdata;
        end
        CEN = ~gnt_any;
        WEN = ~(gnt_any & sel_we);
        OEN = ~(gnt_any & ~sel_we);
    end

    assign rd_owner_d = rd_owner_of(cpu_gnt, cpu_we, dma_gnt, dma_we);

    // Read-owner pipeline: remembers who issued the read so the data lands next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // Read return; gated by reset so a read caught in flight never reports valid
    always_comb begin
        cpu_rvalid = rst_n && (rd_owner_q == OWN_CPU);
        dma_rvalid = rst_n && (rd_owner_q == OWN_DMA);
        cpu_rdata  = cpu_rvalid ? ReadDataMem : 32'h0;
        dma_rdata  = dma_rvalid ? ReadDataMem : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural SRAM on the memory side.
module tb_dmem_arbiter;

    localparam int unsigned AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0]   cpu_rdata;
    logic          dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [31:0]   dma_wdata = '0;
    logic          dma_gnt, dma_rvalid;
    logic [31:0]   dma_rdata;
    logic          CEN, WEN, OEN;
    logic [AW-1:0] A;
    logic [31:0]   Data2Mem;
    logic [31:0]   ReadDataMem;

    logic [31:0]   mem [0:127];
    logic [31:0]   rd_q;

    int n_assert = 0;
    int n_fail   = 0;
    int gcount   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MAX_WAIT  (4),
        .MAX_BURST (8),
        .AW        (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_stall   (cpu_stall),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_lock    (dma_lock),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata),
        .CEN         (CEN),
        .WEN         (WEN),
        .OEN         (OEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem)
    );

    // SRAM model: write or registered read on an enabled cycle; preloaded under reset
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[5] <= 32'hDEADBEEF;
        end else if (!CEN) begin
            if (!WEN) mem[A] <= Data2Mem;
            else if (!OEN) rd_q <= mem[A];
        end
    end
    assign ReadDataMem = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic lock,
                           input logic [AW-1:0] addr, input logic [31:0] wd);
        dma_req = req; dma_we = we; dma_lock = lock; dma_addr = addr; dma_wdata = wd;
    endtask

    // Each step: drive on the falling edge, sample 1 time unit later
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // ---- Reset, with both sides requesting ----
        step();
        set_cpu(1'b1, 1'b1, 7'h11, 32'hAAAA5555);
        set_dma(1'b1, 1'b1, 1'b0, 7'h22, 32'h5555AAAA);
        #1;
        chk("rst cpu_gnt", cpu_gnt, 0);
        chk("rst dma_gnt", dma_gnt, 0);
        chk("rst CEN", CEN, 1);
        chk("rst WEN", WEN, 1);
        chk("rst OEN", OEN, 1);
        chk("rst A", A, 0);
        chk("rst Data2Mem", Data2Mem, 0);
        step();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        rst_n = 1'b1;
        step(); #1;
        chk("idle CEN", CEN, 1);
        chk("idle A", A, 0);
        chk("idle cpu_rvalid", cpu_rvalid, 0);
        chk("idle dma_rvalid", dma_rvalid, 0);

        // ---- CPU-only read of address 5 ----
        step();
        set_cpu(1'b1, 1'b0, 7'h05, '0);
        #1;
        chk("rd5 cpu_gnt", cpu_gnt, 1);
        chk("rd5 CEN", CEN, 0);
        chk("rd5 OEN", OEN, 0);
        chk("rd5 WEN", WEN, 1);
        chk("rd5 A", A, 5);
        chk("rd5 cpu_stall", cpu_stall, 0);
        step();
        set_cpu(1'b0, 1'b0, '0, '0);
        #1;
        chk("rd5 cpu_rvalid", cpu_rvalid, 1);
        chk("rd5 cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd5 dma_rvalid", dma_rvalid, 0);
        chk("rd5 dma_rdata", dma_rdata, 0);
        chk("rd5 cpu_stall idle", cpu_stall, 0);

        // ---- Both requesting: CPU x4, forced DMA, CPU x4 ----
        for (int i = 0; i < 9; i++) begin
            step();
            set_cpu(1'b1, 1'b0, 7'h01, '0);
            set_dma(1'b1, 1'b0, 1'b0, 7'h02, '0);
            #1;
            chk($sformatf("starve%0d cpu_gnt", i), cpu_gnt, (i != 4));
            chk($sformatf("starve%0d dma_gnt", i), dma_gnt, (i == 4));
            chk($sformatf("starve%0d cpu_stall", i), cpu_stall, (i == 4));
            if (i == 4) chk("starve4 A", A, 2);
            if (i == 5) chk("starve5 dma_rvalid", dma_rvalid, 1);
            if (i == 5) chk("starve5 cpu_rvalid", cpu_rvalid, 0);
        end
        step();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("starve end cpu_rvalid", cpu_rvalid, 1);

        // ---- Locked DMA burst, capped at 8 beats ----
        step();
        set_dma(1'b1, 1'b1, 1'b1, 7'h40, 32'h100);
        #1;
        chk("burst0 dma_gnt", dma_gnt, 1);
        chk("burst0 WEN", WEN, 0);
        chk("burst0 A", A, 7'h40);
        if (dma_gnt) gcount++;
        for (int k = 1; k < 9; k++) begin
            step();
            set_cpu(1'b1, 1'b0, 7'h10, '0);
            set_dma(1'b1, 1'b1, 1'b1, 7'(7'h40 + k), 32'h100 + k);
            #1;
            if (dma_gnt) gcount++;
            if (k < 8) begin
                chk($sformatf("burst%0d dma_gnt", k), dma_gnt, 1);
                chk($sformatf("burst%0d cpu_gnt", k), cpu_gnt, 0);
                chk($sformatf("burst%0d cpu_stall", k), cpu_stall, 1);
            end else begin
                chk("burst8 cpu_gnt", cpu_gnt, 1);
                chk("burst8 dma_gnt", dma_gnt, 0);
                chk("burst8 A", A, 7'h10);
            end
        end
        chk("burst grant count", gcount, 8);
        step();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("burst end cpu_rvalid", cpu_rvalid, 1);

        // ---- CPU write vs DMA read, wait below limit; then DMA reads it back ----
        step();
        set_cpu(1'b1, 1'b1, 7'h03, 32'h1234);
        set_dma(1'b1, 1'b0, 1'b0, 7'h03, '0);
        #1;
        chk("wr3 cpu_gnt", cpu_gnt, 1);
        chk("wr3 dma_gnt", dma_gnt, 0);
        chk("wr3 WEN", WEN, 0);
        chk("wr3 OEN", OEN, 1);
        chk("wr3 A", A, 3);
        chk("wr3 Data2Mem", Data2Mem, 32'h1234);
        step();
        set_cpu(1'b0, 1'b0, '0, '0);
        #1;
        chk("wr3 cpu_rvalid", cpu_rvalid, 0);
        chk("wr3 dma_rvalid", dma_rvalid, 0);
        chk("rb3 dma_gnt", dma_gnt, 1);
        chk("rb3 OEN", OEN, 0);
        step();
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("rb3 dma_rvalid", dma_rvalid, 1);
        chk("rb3 dma_rdata", dma_rdata, 32'h1234);
        chk("rb3 cpu_rvalid", cpu_rvalid, 0);
        chk("rb3 cpu_rdata", cpu_rdata, 0);

        // ---- Reset right after a locked DMA read grant ----
        step();
        set_dma(1'b1, 1'b0, 1'b1, 7'h05, '0);
        #1;
        chk("rstflt dma_gnt", dma_gnt, 1);
        step();
        rst_n = 1'b0;
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("rstflt dma_rvalid in rst", dma_rvalid, 0);
        chk("rstflt CEN in rst", CEN, 1);
        step();
        rst_n = 1'b1;
        #1;
        chk("rstflt CEN after", CEN, 1);
        chk("rstflt dma_rvalid after", dma_rvalid, 0);
        chk("rstflt cpu_rvalid after", cpu_rvalid, 0);
        step();
        set_cpu(1'b1, 1'b0, 7'h07, '0);
        set_dma(1'b1, 1'b0, 1'b0, 7'h08, '0);
        #1;
        chk("rstflt cpu_gnt", cpu_gnt, 1);
        chk("rstflt dma_gnt", dma_gnt, 0);
        step();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        #1;

        // ---- DMA drops its request mid-burst ----
        step();
        set_dma(1'b1, 1'b1, 1'b1, 7'h50, 32'h50);
        #1;
        chk("drop0 dma_gnt", dma_gnt, 1);
        for (int k = 1; k < 3; k++) begin
            step();
            set_cpu(1'b1, 1'b0, 7'h08, '0);
            set_dma(1'b1, 1'b1, 1'b1, 7'(7'h50 + k), 32'h50 + k);
            #1;
            chk($sformatf("drop%0d dma_gnt", k), dma_gnt, 1);
            chk($sformatf("drop%0d cpu_stall", k), cpu_stall, 1);
        end
        step();
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("drop3 dma_gnt", dma_gnt, 0);
        chk("drop3 cpu_gnt", cpu_gnt, 0);
        chk("drop3 cpu_stall", cpu_stall, 1);
        chk("drop3 CEN", CEN, 1);
        step();
        set_dma(1'b1, 1'b0, 1'b0, 7'h09, '0);
        #1;
        chk("drop4 cpu_gnt", cpu_gnt, 1);
        chk("drop4 dma_gnt", dma_gnt, 0);
        chk("drop4 A", A, 7'h08);
        step();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("drop end cpu_rvalid", cpu_rvalid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
